gbm_path_sequencer: RTL and testbench
=====================================

Name: gbm_path_sequencer

Overview:
- Upstream controller for the GBM step pipeline; generates full Monte-Carlo price paths for the LSM engine.
- Issues one GBM step per accepted normal sample z, in step-major order: all paths for step 1, then all paths for step 2, and so on.
- Keeps each path's current price in an internal state RAM and feeds the GBM pipeline's S_t back as the next step's S_0.
- Streams every (path, step, price) triple to the downstream regression store.

Parameters:
- WIDTH, 32, data width; all prices, rates and z values are signed fixed-point Q(WIDTH-QFRAC).QFRAC.
- QFRAC, 16, fractional bits.
- N_PATHS, 64, paths per run (>=1).
- N_STEPS, 16, time steps per path (>=1).
- MAX_INFLIGHT, 32, depth of the tag FIFO; also the maximum number of outstanding GBM steps.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a run when idle
- s_init  in  WIDTH  initial spot price, latched on start
- z_valid  in  1  normal sample valid
- z_ready  out  1  sample accepted when z_valid && z_ready
- z_data  in  WIDTH  normal sample
- gbm_valid_in  out  1  issue strobe to the GBM pipeline
- gbm_z  out  WIDTH  z for the issued step
- gbm_s0  out  WIDTH  prior price of the path being stepped
- gbm_valid_out  in  1  GBM result strobe
- gbm_s_t  in  WIDTH  GBM result price
- out_valid  out  1  path price valid (no backpressure)
- out_path  out  $clog2(N_PATHS)  path index
- out_step  out  $clog2(N_STEPS+1)  step index, 1..N_STEPS
- out_price  out  WIDTH  price
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- err  out  1  sticky protocol error

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: all outputs 0; FSM in IDLE; tag FIFO empty; step counter 0; path counter 0. State RAM contents are don't-care.
- FSM states:
  - IDLE: start -> latch s_init, set step=1, path=0, go to ISSUE. start while busy is ignored.
  - ISSUE: z_ready = !fifo_full. On each z handshake:
    - gbm_valid_in=1 for exactly one cycle, registered: gbm_z=z_data; gbm_s0 = s_init if step==1, else RAM[path].
    - Push path onto the tag FIFO; increment path.
    - When path wraps from N_PATHS-1 to 0, go to DRAIN.
  - DRAIN: z_ready=0. Wait for the tag FIFO to empty (guarantees RAM[p] is current before the next sweep reads it).
    - Empty and step==N_STEPS -> DONE.
    - Otherwise step+1 -> ISSUE.
  - DONE: pulse done for one cycle, clear busy, go to IDLE.
- busy=1 in every state except IDLE.
- RAM read is registered: z_ready is asserted only when RAM data for the current path is ready, so gbm_s0 is aligned with the z handshake with no bubble.
- Result handling: the GBM pipeline is fixed-latency and in-order. On gbm_valid_out:
  - Pop tag p.
  - Write RAM[p] = gbm_s_t.
  - Next cycle (registered): out_valid=1, out_path=p, out_step=step, out_price=gbm_s_t.
- Same-cycle push and pop on the tag FIFO are legal; occupancy is unchanged.
- gbm_valid_out with an empty FIFO: set err, drop the result, no out_valid. err clears only on reset.
- Prices pass through unmodified; the block does no arithmetic beyond counters.
- Reset mid-run: everything returns to its reset value; no done pulse; later GBM results are flagged as err.

Optional Feature:
- GBM_SEQ_ANTITHETIC_EN
- Defined:
  - Paths are paired (2k, 2k+1). Odd paths consume no sample; they are issued with gbm_z = -z of the preceding even path (two's complement; 0x8000_0000 saturates to 0x7FFF_FFFF), one cycle after it.
  - z_ready is low in that cycle.
  - N_PATHS must be even; the constraint is checked with an elaboration assertion.
- Undefined: every path consumes its own sample.

Test Plan:
- Basic run: N_PATHS=4, N_STEPS=2, s_init=0x0064_0000, GBM stub with latency 12 returning S_0+z, z stream 0x0001_0000 every cycle.
  -> 8 outputs: step1 paths 0-3 price 0x0065_0000; step2 paths 0-3 price 0x0066_0000; done exactly once; 8 z accepted.
- Drain check: same setup.
  -> no gbm_valid_in for step 2 until 12 cycles after the last step-1 issue; step-2 gbm_s0 = 0x0065_0000.
- Backpressure: MAX_INFLIGHT=2, stub latency 12, N_PATHS=4.
  -> z_ready low while 2 steps are outstanding; never more than 2 in flight; outputs as in the basic run.
- Spurious result: gbm_valid_out pulsed while IDLE.
  -> err=1 and stays set, out_valid=0; a following run completes normally with err still 1.
- Reset mid-run: rst_n low during step 1, path 2.
  -> all outputs 0; a new start with s_init=0x000A_0000 gives step-1 outputs 0x000B_0000.
- Antithetic (GBM_SEQ_ANTITHETIC_EN, N_PATHS=2): z=0x0000_8000.
  -> path 0 gets +0x8000, path 1 gets 0xFFFF_8000; one sample consumed per step.

Source files
------------

// File: rtl/gbm_path_sequencer.sv
// gbm_path_sequencer
//   Upstream sequencer for the GBM step pipeline. Issues one GBM step per
//   accepted normal sample in step-major order (all paths of step 1, then
//   all paths of step 2, ...). Each path's latest price is held in a state
//   RAM and fed back as S_0 of the next step. Every returned result is
//   streamed out as a (path, step, price) triple.
//
//   Optional build macro: GBM_SEQ_ANTITHETIC_EN
//     Paths are paired (2k, 2k+1). The odd path takes no sample and is
//     issued one cycle after its even partner with the saturated negation
//     of the partner's z. N_PATHS must be even.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, s_init   run start pulse and initial spot price (latched on start)
//   z_valid/z_ready/z_data           normal-sample stream
//   gbm_valid_in/gbm_z/gbm_s0        issue to the GBM pipeline
//   gbm_valid_out/gbm_s_t            in-order results from the GBM pipeline
//   out_valid/out_path/out_step/out_price   result stream, no backpressure
//   busy, done, err  run in progress, end-of-run pulse, sticky protocol error
module gbm_path_sequencer #(
  parameter int WIDTH        = 32,
  parameter int QFRAC        = 16,
  parameter int N_PATHS      = 64,
  parameter int N_STEPS      = 16,
  parameter int MAX_INFLIGHT = 32,
  localparam int PW = (N_PATHS > 1) ? $clog2(N_PATHS) : 1,
  localparam int SW = $clog2(N_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] s_init,
  input  logic             z_valid,
  output logic             z_ready,
  input  logic [WIDTH-1:0] z_data,
  output logic             gbm_valid_in,
  output logic [WIDTH-1:0] gbm_z,
  output logic [WIDTH-1:0] gbm_s0,
  input  logic             gbm_valid_out,
  input  logic [WIDTH-1:0] gbm_s_t,
  output logic             out_valid,
  output logic [PW-1:0]    out_path,
  output logic [SW-1:0]    out_step,
  output logic [WIDTH-1:0] out_price,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int FW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  if (QFRAC < 0 || QFRAC >= WIDTH) begin : g_bad_qfrac
    $error("gbm_path_sequencer: QFRAC must lie in [0, WIDTH)");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    path, path_nxt;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] s_init_q;
  logic [WIDTH-1:0] ram [N_PATHS];
  logic [WIDTH-1:0] ram_q;
  logic [PW-1:0]    tag_mem [MAX_INFLIGHT];
  logic [FW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_full, fifo_empty;
  logic             take, issue, pop, last_path;
  logic [WIDTH-1:0] issue_z;

  assign fifo_full  = (count == CW'(MAX_INFLIGHT));
  assign fifo_empty = (count == '0);
  assign take       = z_valid && z_ready;
  assign pop        = gbm_valid_out && !fifo_empty;
  assign last_path  = (path == PW'(N_PATHS - 1));
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

`ifdef GBM_SEQ_ANTITHETIC_EN
  if (N_PATHS % 2 != 0) begin : g_bad_pairs
    $error("gbm_path_sequencer: antithetic pairing needs an even N_PATHS");
  end

  logic             anti_pend;
  logic [WIDTH-1:0] z_neg, z_neg_d;

  // Negation saturates so the most negative code maps to the most positive.
  assign z_neg_d = (z_data == {1'b1, {(WIDTH-1){1'b0}}}) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                          : -z_data;
  assign z_ready = (state == S_ISSUE) && !fifo_full && !anti_pend;
  assign issue   = take || (anti_pend && !fifo_full);
  assign issue_z = anti_pend ? z_neg : z_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anti_pend <= 1'b0;
      z_neg     <= '0;
    end else if (take) begin
      anti_pend <= 1'b1;
      z_neg     <= z_neg_d;
    end else if (anti_pend && !fifo_full) begin
      anti_pend <= 1'b0;
    end
  end
`else
  assign z_ready = (state == S_ISSUE) && !fifo_full;
  assign issue   = take;
  assign issue_z = z_data;
`endif

  always_comb begin
    state_nxt = state;
    path_nxt  = path;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ISSUE;
          path_nxt  = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          path_nxt = last_path ? '0 : path + PW'(1);
          if (last_path) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_nxt = (step == SW'(N_STEPS)) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      path         <= '0;
      step         <= '0;
      s_init_q     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      gbm_valid_in <= 1'b0;
      gbm_z        <= '0;
      gbm_s0       <= '0;
      out_valid    <= 1'b0;
      out_path     <= '0;
      out_step     <= '0;
      out_price    <= '0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;
      path  <= path_nxt;

      if (state == S_IDLE && start) begin
        s_init_q <= s_init;
        step     <= SW'(1);
      end else if (state == S_DRAIN && fifo_empty && step != SW'(N_STEPS)) begin
        step <= step + SW'(1);
      end

      gbm_valid_in <= issue;
      if (issue) begin
        gbm_z  <= issue_z;
        gbm_s0 <= (step == SW'(1)) ? s_init_q : ram_q;
        wr_ptr <= (wr_ptr == FW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + FW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == FW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + FW'(1);

      unique case ({issue, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      out_valid <= pop;
      if (pop) begin
        out_path  <= tag_mem[rd_ptr];
        out_step  <= step;
        out_price <= gbm_s_t;
      end

      if (gbm_valid_out && fifo_empty) err <= 1'b1;
    end
  end

  // RAM read is addressed by the next path so ram_q always holds RAM[path];
  // the sweep never writes a path it has not yet issued, so no bypass needed.
  always_ff @(posedge clk) begin
    if (pop)   ram[tag_mem[rd_ptr]] <= gbm_s_t;
    if (issue) tag_mem[wr_ptr]      <= path;
    ram_q <= ram[path_nxt];
  end

endmodule

// File: tb/tb_gbm_path_sequencer.sv
// tb_gbm_path_sequencer
//   Two sequencer instances (N_PATHS=4, N_STEPS=2): instance 0 with a deep
//   tag FIFO, instance 1 with MAX_INFLIGHT=2. Each drives a GBM stub with a
//   fixed latency of 12 cycles that returns S_0 + z.
module tb_gbm_path_sequencer;
  localparam int NP   = 4;
  localparam int NS   = 2;
  localparam int LAT  = 12;
  localparam int LOGN = 64;

  typedef struct {
    int unsigned path;
    int unsigned step;
    logic [31:0] price;
  } vec_t;

`ifdef GBM_SEQ_ANTITHETIC_EN
  localparam logic [31:0] B1O = 32'h0063_0000, B2O = 32'h0062_0000;
  localparam logic [31:0] R1O = 32'h0009_0000, R2O = 32'h0008_0000;
  localparam int unsigned HS_RUN = 4;
`else
  localparam logic [31:0] B1O = 32'h0065_0000, B2O = 32'h0066_0000;
  localparam logic [31:0] R1O = 32'h000B_0000, R2O = 32'h000C_0000;
  localparam int unsigned HS_RUN = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] s_init, z_data;
  logic [1:0]  start_s, zv, zr, gvi, gvo, ov, busy, done, err, spur;
  logic [31:0] gz [2], gs0 [2], gst [2], op [2];
  logic [1:0]  opath [2], ostep [2];

  logic [LAT-1:0] vp [2] = '{default: '0};
  logic [31:0]    dp [2][LAT] = '{default: '{default: '0}};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gbm_path_sequencer #(
      .WIDTH(32), .QFRAC(16), .N_PATHS(NP), .N_STEPS(NS),
      .MAX_INFLIGHT((g == 0) ? 32 : 2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_s[g]), .s_init(s_init),
      .z_valid(zv[g]), .z_ready(zr[g]), .z_data(z_data),
      .gbm_valid_in(gvi[g]), .gbm_z(gz[g]), .gbm_s0(gs0[g]),
      .gbm_valid_out(gvo[g]), .gbm_s_t(gst[g]),
      .out_valid(ov[g]), .out_path(opath[g]), .out_step(ostep[g]), .out_price(op[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );
    assign gvo[g] = vp[g][LAT-1] | spur[g];
    assign gst[g] = dp[g][LAT-1];
  end

  // GBM stub: fixed latency, in order, S_t = S_0 + z
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      vp[g]    <= {vp[g][LAT-2:0], gvi[g]};
      dp[g][0] <= gz[g] + gs0[g];
      for (int k = 1; k < LAT; k++) dp[g][k] <= dp[g][k-1];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_hs [2] = '{0, 0};
  int unsigned n_iss [2] = '{0, 0};
  int unsigned n_ret [2] = '{0, 0};
  int unsigned n_out [2] = '{0, 0};
  int unsigned n_done [2] = '{0, 0};
  int unsigned bp_viol = 0, bp_seen = 0, max_oc = 0, oc;
  logic [31:0] lz [2][LOGN], ls0 [2][LOGN], lprice [2][LOGN];
  int unsigned lcyc [2][LOGN], lpath [2][LOGN], lstep [2][LOGN];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (zv[g] && zr[g]) n_hs[g]++;
      if (gvi[g]) begin
        if (n_iss[g] < LOGN) begin
          lz[g][n_iss[g]]   = gz[g];
          ls0[g][n_iss[g]]  = gs0[g];
          lcyc[g][n_iss[g]] = cyc;
        end
        n_iss[g]++;
      end
      if (g == 1) begin
        oc = n_iss[1] - n_ret[1];
        if (oc > max_oc) max_oc = oc;
        if (oc >= 2) begin
          bp_seen = 1;
          if (zr[1]) bp_viol++;
        end
      end
      if (gvo[g]) n_ret[g]++;
      if (ov[g]) begin
        if (n_out[g] < LOGN) begin
          lpath[g][n_out[g]]  = 32'(opath[g]);
          lstep[g][n_out[g]]  = 32'(ostep[g]);
          lprice[g][n_out[g]] = op[g];
        end
        n_out[g]++;
      end
      if (done[g]) n_done[g]++;
    end
  end

  int unsigned n_chk = 0, n_fail = 0;
  vec_t tab [2][8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_ctl_g%0d", tag, g),
          64'({zr[g], gvi[g], ov[g], busy[g], done[g], err[g], opath[g], ostep[g]}), 64'd0);
      chk($sformatf("%s_data_g%0d", tag, g), {gz[g] | gs0[g], op[g]}, 64'd0);
    end
  endtask

  task automatic run(input int g, input logic [31:0] si, input logic [31:0] z);
    bit seen;
    seen       = 1'b0;
    s_init     = si;
    z_data     = z;
    start_s[g] = 1'b1;
    zv[g]      = 1'b1;
    @(posedge clk); #1 start_s[g] = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (done[g]) seen = 1'b1;
    end
    zv[g] = 1'b0;
    chk($sformatf("done_seen_g%0d", g), 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input int g, input int unsigned ob, input int t);
    chk($sformatf("n_out_g%0d_t%0d", g, t), 64'(n_out[g] - ob), 64'd8);
    for (int i = 0; i < 8; i++) begin
      int unsigned k;
      k = ob + i;
      chk($sformatf("g%0d_t%0d_o%0d_path", g, t, i), 64'(lpath[g][k]), 64'(tab[t][i].path));
      chk($sformatf("g%0d_t%0d_o%0d_step", g, t, i), 64'(lstep[g][k]), 64'(tab[t][i].step));
      chk($sformatf("g%0d_t%0d_o%0d_price", g, t, i), 64'(lprice[g][k]), 64'(tab[t][i].price));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned ob0, ob1, ib0, hb0, hb1, db0, db1, ib;
    bit seen;

    tab[0][0] = '{0, 1, 32'h0065_0000}; tab[0][1] = '{1, 1, B1O};
    tab[0][2] = '{2, 1, 32'h0065_0000}; tab[0][3] = '{3, 1, B1O};
    tab[0][4] = '{0, 2, 32'h0066_0000}; tab[0][5] = '{1, 2, B2O};
    tab[0][6] = '{2, 2, 32'h0066_0000}; tab[0][7] = '{3, 2, B2O};
    tab[1][0] = '{0, 1, 32'h000B_0000}; tab[1][1] = '{1, 1, R1O};
    tab[1][2] = '{2, 1, 32'h000B_0000}; tab[1][3] = '{3, 1, R1O};
    tab[1][4] = '{0, 2, 32'h000C_0000}; tab[1][5] = '{1, 2, R2O};
    tab[1][6] = '{2, 2, 32'h000C_0000}; tab[1][7] = '{3, 2, R2O};

    rst_n = 1'b0; start_s = '0; zv = '0; spur = '0; s_init = '0; z_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic run on both instances in parallel
    ob0 = n_out[0]; ob1 = n_out[1]; ib0 = n_iss[0];
    hb0 = n_hs[0];  hb1 = n_hs[1];  db0 = n_done[0]; db1 = n_done[1];
    fork
      run(0, 32'h0064_0000, 32'h0001_0000);
      run(1, 32'h0064_0000, 32'h0001_0000);
    join
    check_outs(0, ob0, 0);
    check_outs(1, ob1, 0);
    chk("basic_hs_g0", 64'(n_hs[0] - hb0), 64'(HS_RUN));
    chk("basic_hs_g1", 64'(n_hs[1] - hb1), 64'(HS_RUN));
    chk("basic_done_g0", 64'(n_done[0] - db0), 64'd1);
    chk("basic_done_g1", 64'(n_done[1] - db1), 64'd1);
    chk("basic_busy", 64'(busy), 64'd0);
    chk("basic_err", 64'(err), 64'd0);

    // Drain: step 2 waits for all step-1 results; S_0 feeds back per path
    chk("drain_issues", 64'(n_iss[0] - ib0), 64'd8);
    chk("drain_gap_ge13", 64'(lcyc[0][ib0+4] - lcyc[0][ib0+3] >= 13), 64'd1);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("s0_step1_p%0d", p), 64'(ls0[0][ib0+p]), 64'h0064_0000);
      chk($sformatf("s0_step2_p%0d", p), 64'(ls0[0][ib0+4+p]), 64'(tab[0][p].price));
    end

    // Backpressure on the 2-deep instance
    chk("bp_max_inflight", 64'(max_oc), 64'd2);
    chk("bp_limit_seen", 64'(bp_seen), 64'd1);
    chk("bp_zready_low_at_limit", 64'(bp_viol), 64'd0);

    // Spurious result while idle
    ob0 = n_out[0];
    spur[0] = 1'b1;
    @(posedge clk); #1 spur[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_err", 64'(err[0]), 64'd1);
    chk("spur_no_out", 64'(n_out[0] - ob0), 64'd0);
    chk("spur_other_err", 64'(err[1]), 64'd0);
    ob0 = n_out[0];
    run(0, 32'h0064_0000, 32'h0001_0000);
    check_outs(0, ob0, 0);
    chk("spur_err_sticky", 64'(err[0]), 64'd1);

    // Reset mid-run at step 1, path 2
    ib = n_iss[0];
    s_init = 32'h0064_0000; z_data = 32'h0001_0000;
    start_s[0] = 1'b1; zv[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk); #1;
      if (n_iss[0] - ib >= 2) seen = 1'b1;
    end
    chk("rst_reach_path2", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    reset_zero("midrst");
    zv[0] = 1'b0;
    ob0 = n_out[0]; db0 = n_done[0];
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_stale_err", 64'(err[0]), 64'd1);
    chk("rst_no_out", 64'(n_out[0] - ob0), 64'd0);
    chk("rst_no_done", 64'(n_done[0] - db0), 64'd0);
    chk("rst_idle", 64'(busy[0]), 64'd0);
    ob0 = n_out[0];
    run(0, 32'h000A_0000, 32'h0001_0000);
    check_outs(0, ob0, 1);

`ifdef GBM_SEQ_ANTITHETIC_EN
    // Antithetic pairing: odd path takes -z of its partner, next cycle
    ib = n_iss[0]; hb0 = n_hs[0];
    run(0, 32'h0064_0000, 32'h0000_8000);
    chk("anti_p0_z", 64'(lz[0][ib]), 64'h0000_8000);
    chk("anti_p1_z", 64'(lz[0][ib+1]), 64'hFFFF_8000);
    chk("anti_adjacent", 64'(lcyc[0][ib+1] - lcyc[0][ib]), 64'd1);
    chk("anti_hs", 64'(n_hs[0] - hb0), 64'd4);
    ib = n_iss[0];
    run(0, 32'h0064_0000, 32'h8000_0000);
    chk("anti_sat_z", 64'(lz[0][ib+1]), 64'h7FFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
